// File: rtl/slv_i2c_reg_fsm.sv
// slv_i2c_reg_fsm: I2C slave protocol FSM in front of a small register file.
// A master write sends the register pointer as its first byte. Each later byte is
// written at the pointer, and the pointer then increments. A master read returns
// bytes from the pointer, which also increments. The pointer wraps at NUM_REGS.
// Optional feature: define SLV_I2C_GCALL_EN to acknowledge the general-call address
// (7'h00, write). General-call bytes then appear on O_GC_DATA with the O_GC_VL strobe.
module slv_i2c_reg_fsm #(
   parameter int                 DATA_SZ  = 8,
   parameter int                 ADDR_SZ  = 7,
   parameter logic [ADDR_SZ-1:0] SLV_ADDR = 7'h50,
   parameter int                 NUM_REGS = 16,
   localparam int                PTR_SZ   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               I_SCL,
   input  logic               I_SDA,
   input  logic               I_RS_IO_SCL,
   input  logic               I_FL_IO_SCL,
   input  logic               I_RS_IO_SDA,
   input  logic               I_FL_IO_SDA,
   input  logic               I_MDL_LW_IO_SCL,
   input  logic [DATA_SZ-1:0] I_RD_DATA,
   output logic               O_SDA,
   output logic               O_BUSY,
   output logic [PTR_SZ-1:0]  O_REG_ADDR,
   output logic               O_WR_EN,
   output logic [DATA_SZ-1:0] O_WR_DATA,
   output logic               O_RD_EN,
`ifdef SLV_I2C_GCALL_EN
   output logic               O_ACK_MSTR,
   output logic [DATA_SZ-1:0] O_GC_DATA,
   output logic               O_GC_VL
`else
   output logic               O_ACK_MSTR
`endif
);

   localparam int                 BCNT_SZ  = $clog2(DATA_SZ + 1);
   localparam logic [BCNT_SZ-1:0] LAST_BIT = BCNT_SZ'(DATA_SZ - 1);

   typedef enum logic [3:0] {
      IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, MSTR_ACK, IGNORE
   } state_t;

   state_t               state_reg, state_next;
   logic [BCNT_SZ-1:0]   bit_cnt_reg, bit_cnt_next;
   logic [DATA_SZ-1:0]   shift_reg, shift_next;
   logic                 sda_reg, sda_next;
   logic                 busy_reg, busy_next;
   logic                 phase_reg, phase_next;   // ACK slot: SDA driven (slave) / sampled (master)
   logic                 rw_reg, rw_next;
   logic [PTR_SZ-1:0]    ptr_reg, ptr_next, ptr_inc;
   logic                 wr_en_reg, wr_en_next;
   logic [DATA_SZ-1:0]   wr_data_reg, wr_data_next;
   logic                 rd_en_reg, rd_en_next;
   logic                 rd_dly_reg;              // register-file data valid this cycle
   logic                 ack_mstr_reg, ack_mstr_next;
   logic                 gc_mode;

   logic                 start_evt, stop_evt, last_bit, ack_done;
   logic [DATA_SZ-1:0]   rx_byte;
   logic                 addr_ok, ptr_ok, ptr_accept;

`ifdef SLV_I2C_GCALL_EN
   logic                 gc_reg, gc_next;
   logic [DATA_SZ-1:0]   gc_data_reg, gc_data_next;
   logic                 gc_vl_reg, gc_vl_next;
   logic                 gc_hit;

   assign gc_hit  = (rx_byte[DATA_SZ-1:1] == '0) && !rx_byte[0];
   assign gc_mode = gc_reg;
   assign addr_ok = (rx_byte[DATA_SZ-1:1] == SLV_ADDR) || gc_hit;
`else
   assign gc_mode = 1'b0;
   assign addr_ok = (rx_byte[DATA_SZ-1:1] == SLV_ADDR);
`endif

   assign start_evt  = I_FL_IO_SDA & I_SCL;
   assign stop_evt   = I_RS_IO_SDA & I_SCL;
   assign last_bit   = I_RS_IO_SCL && (bit_cnt_reg == LAST_BIT);
   assign ack_done   = I_FL_IO_SCL && phase_reg;
   assign rx_byte    = {shift_reg[DATA_SZ-2:0], I_SDA};
   assign ptr_ok     = (32'(rx_byte) < NUM_REGS);
   assign ptr_accept = ptr_ok || gc_mode;
   assign ptr_inc    = (ptr_reg == PTR_SZ'(NUM_REGS - 1)) ? '0 : ptr_reg + PTR_SZ'(1);

   // State register and all datapath registers; reset releases the bus at once
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg    <= IDLE;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         sda_reg      <= 1'b1;
         busy_reg     <= 1'b0;
         phase_reg    <= 1'b0;
         rw_reg       <= 1'b0;
         ptr_reg      <= '0;
         wr_en_reg    <= 1'b0;
         wr_data_reg  <= '0;
         rd_en_reg    <= 1'b0;
         rd_dly_reg   <= 1'b0;
         ack_mstr_reg <= 1'b0;
`ifdef SLV_I2C_GCALL_EN
         gc_reg       <= 1'b0;
         gc_data_reg  <= '0;
         gc_vl_reg    <= 1'b0;
`endif
      end else begin
         state_reg    <= state_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         sda_reg      <= sda_next;
         busy_reg     <= busy_next;
         phase_reg    <= phase_next;
         rw_reg       <= rw_next;
         ptr_reg      <= ptr_next;
         wr_en_reg    <= wr_en_next;
         wr_data_reg  <= wr_data_next;
         rd_en_reg    <= rd_en_next;
         rd_dly_reg   <= rd_en_reg;
         ack_mstr_reg <= ack_mstr_next;
`ifdef SLV_I2C_GCALL_EN
         gc_reg       <= gc_next;
         gc_data_reg  <= gc_data_next;
         gc_vl_reg    <= gc_vl_next;
`endif
      end
   end

   // Next-state logic: STOP beats START, START beats any bit event
   always_comb begin
      state_next = state_reg;
      if (stop_evt) begin
         state_next = IDLE;
      end else if (start_evt) begin
         state_next = ADDR;
      end else begin
         case (state_reg)
            ADDR:     if (last_bit) state_next = addr_ok ? ADDR_ACK : IGNORE;
            ADDR_ACK: if (ack_done) state_next = rw_reg ? RD_DATA : PTR;
            PTR:      if (last_bit) state_next = ptr_accept ? PTR_ACK : IGNORE;
            PTR_ACK:  if (ack_done) state_next = gc_mode ? PTR : WR_DATA;
            WR_DATA:  if (last_bit) state_next = WR_ACK;
            WR_ACK:   if (ack_done) state_next = WR_DATA;
            RD_DATA:  if (last_bit) state_next = MSTR_ACK;
            MSTR_ACK: if (ack_done) state_next = ack_mstr_reg ? IGNORE : RD_DATA;
            default:  state_next = state_reg;
         endcase
      end
   end

   // Output/datapath logic: SDA only moves on the mid-low strobe except at START/STOP
   always_comb begin
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      sda_next      = sda_reg;
      busy_next     = busy_reg;
      phase_next    = phase_reg;
      rw_next       = rw_reg;
      ptr_next      = ptr_reg;
      wr_en_next    = 1'b0;
      wr_data_next  = wr_data_reg;
      rd_en_next    = 1'b0;
      ack_mstr_next = ack_mstr_reg;
`ifdef SLV_I2C_GCALL_EN
      gc_next       = gc_reg;
      gc_data_next  = gc_data_reg;
      gc_vl_next    = 1'b0;
`endif
      if (stop_evt) begin
         sda_next     = 1'b1;
         busy_next    = 1'b0;
         bit_cnt_next = '0;
         phase_next   = 1'b0;
      end else if (start_evt) begin
         sda_next     = 1'b1;
         busy_next    = 1'b1;
         bit_cnt_next = '0;
         phase_next   = 1'b0;
`ifdef SLV_I2C_GCALL_EN
         gc_next      = 1'b0;
`endif
      end else begin
         if (wr_en_reg) ptr_next = ptr_inc;
         case (state_reg)
            ADDR, PTR, WR_DATA: begin
               if (I_MDL_LW_IO_SCL) sda_next = 1'b1;
               if (I_RS_IO_SCL) begin
                  shift_next   = rx_byte;
                  bit_cnt_next = bit_cnt_reg + BCNT_SZ'(1);
               end
               if (last_bit) begin
                  bit_cnt_next = '0;
                  phase_next   = 1'b0;
                  if (state_reg == ADDR) begin
                     rw_next = rx_byte[0];
`ifdef SLV_I2C_GCALL_EN
                     gc_next = gc_hit;
`endif
                  end else if (state_reg == WR_DATA) begin
                     wr_data_next = rx_byte;
                     wr_en_next   = 1'b1;
`ifdef SLV_I2C_GCALL_EN
                  end else if (gc_reg) begin
                     gc_data_next = rx_byte;
                     gc_vl_next   = 1'b1;
`endif
                  end else if (ptr_ok) begin
                     ptr_next = rx_byte[PTR_SZ-1:0];
                  end
               end
            end
            ADDR_ACK, PTR_ACK, WR_ACK: begin
               if (I_MDL_LW_IO_SCL && !phase_reg) begin
                  sda_next   = 1'b0;
                  phase_next = 1'b1;
               end
               if (ack_done) begin
                  phase_next   = 1'b0;
                  bit_cnt_next = '0;
                  if (state_reg == ADDR_ACK && rw_reg) rd_en_next = 1'b1;
               end
            end
            RD_DATA: begin
               if (rd_dly_reg) begin
                  shift_next = I_RD_DATA;
                  ptr_next   = ptr_inc;
               end
               if (I_MDL_LW_IO_SCL) begin
                  sda_next   = shift_reg[DATA_SZ-1];
                  shift_next = {shift_reg[DATA_SZ-2:0], 1'b0};
               end
               if (I_RS_IO_SCL) bit_cnt_next = bit_cnt_reg + BCNT_SZ'(1);
               if (last_bit) begin
                  bit_cnt_next = '0;
                  phase_next   = 1'b0;
               end
            end
            MSTR_ACK: begin
               if (I_MDL_LW_IO_SCL && !phase_reg) sda_next = 1'b1;
               if (I_RS_IO_SCL && !phase_reg) begin
                  ack_mstr_next = I_SDA;
                  phase_next    = 1'b1;
               end
               if (ack_done) begin
                  phase_next   = 1'b0;
                  bit_cnt_next = '0;
                  if (!ack_mstr_reg) rd_en_next = 1'b1;
               end
            end
            IGNORE: begin
               if (I_MDL_LW_IO_SCL) sda_next = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign O_SDA      = sda_reg;
   assign O_BUSY     = busy_reg;
   assign O_REG_ADDR = ptr_reg;
   assign O_WR_EN    = wr_en_reg;
   assign O_WR_DATA  = wr_data_reg;
   assign O_RD_EN    = rd_en_reg;
   assign O_ACK_MSTR = ack_mstr_reg;
`ifdef SLV_I2C_GCALL_EN
   assign O_GC_DATA  = gc_data_reg;
   assign O_GC_VL    = gc_vl_reg;
`endif

endmodule

// File: tb/tb_slv_i2c_reg_fsm.sv
// tb_slv_i2c_reg_fsm: directed bus-level bench for slv_i2c_reg_fsm (default build).
module tb_slv_i2c_reg_fsm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       scl = 1'b1, m_sda = 1'b1;
   logic       rs_scl = 1'b0, fl_scl = 1'b0, rs_sda = 1'b0, fl_sda = 1'b0, mdl = 1'b0;
   logic [7:0] rd_data = 8'h00;
   logic       o_sda, o_busy, o_wr_en, o_rd_en, o_ack_mstr;
   logic [3:0] o_reg_addr;
   logic [7:0] o_wr_data;
   logic       sda_bus;

   int tests = 0;
   int fails = 0;

   assign sda_bus = m_sda & o_sda;

   always #5 clk = ~clk;

   slv_i2c_reg_fsm dut (
      .CLK(clk), .RST(rst), .I_SCL(scl), .I_SDA(sda_bus),
      .I_RS_IO_SCL(rs_scl), .I_FL_IO_SCL(fl_scl),
      .I_RS_IO_SDA(rs_sda), .I_FL_IO_SDA(fl_sda),
      .I_MDL_LW_IO_SCL(mdl), .I_RD_DATA(rd_data),
      .O_SDA(o_sda), .O_BUSY(o_busy), .O_REG_ADDR(o_reg_addr),
      .O_WR_EN(o_wr_en), .O_WR_DATA(o_wr_data), .O_RD_EN(o_rd_en),
      .O_ACK_MSTR(o_ack_mstr)
   );

   // Register file with one-cycle registered read
   logic [7:0] regs [16];
   always_ff @(posedge clk) begin
      if (o_wr_en) regs[o_reg_addr] <= o_wr_data;
      if (o_rd_en) rd_data <= regs[o_reg_addr];
   end

   // Strobe logs
   int wr_cnt = 0, rd_cnt = 0, sda_low_cnt = 0;
   int wr_addr_log [64];
   int wr_data_log [64];
   int rd_addr_log [64];
   always @(posedge clk) begin
      if (!rst && o_wr_en && wr_cnt < 64) begin
         wr_addr_log[wr_cnt] = int'(o_reg_addr);
         wr_data_log[wr_cnt] = int'(o_wr_data);
         wr_cnt++;
      end
      if (!rst && o_rd_en && rd_cnt < 64) begin
         rd_addr_log[rd_cnt] = int'(o_reg_addr);
         rd_cnt++;
      end
      if (o_sda == 1'b0) sda_low_cnt++;
   end

   task automatic tick();
      @(negedge clk);
   endtask

   // One SCL period; starts and ends with SCL high, samples the bus on the rising edge
   task automatic bit_clk(input logic b, output logic smp);
      scl = 1'b0; fl_scl = 1'b1; tick(); fl_scl = 1'b0;
      repeat (3) tick();
      m_sda = b; mdl = 1'b1; tick(); mdl = 1'b0;
      repeat (3) tick();
      scl = 1'b1; rs_scl = 1'b1; smp = sda_bus; tick(); rs_scl = 1'b0;
      repeat (3) tick();
   endtask

   task automatic i2c_start();
      m_sda = 1'b0; fl_sda = 1'b1; tick(); fl_sda = 1'b0;
      repeat (3) tick();
   endtask

   task automatic i2c_rstart();
      logic s;
      bit_clk(1'b1, s);
      i2c_start();
   endtask

   task automatic i2c_stop();
      logic s;
      bit_clk(1'b0, s);
      m_sda = 1'b1; rs_sda = 1'b1; tick(); rs_sda = 1'b0;
      repeat (3) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_clk(b[i], s);
      bit_clk(1'b1, ack);
   endtask

   task automatic recv_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_clk(1'b1, s);
         d[i] = s;
      end
      bit_clk(mack, s);
   endtask

   task automatic test_reset();
      rst = 1'b1; repeat (3) tick(); rst = 1'b0; tick();
      $display("[TB] reset");
      tests++;
      if ({o_sda, o_busy, o_reg_addr, o_wr_en, o_wr_data, o_rd_en, o_ack_mstr} !== 17'h10000) begin
         fails++;
         $display("FAIL reset_outputs: got sda=%b busy=%b addr=%0d we=%b wd=%h re=%b am=%b expected sda=1 rest 0",
                  o_sda, o_busy, o_reg_addr, o_wr_en, o_wr_data, o_rd_en, o_ack_mstr);
      end
   endtask

   task automatic test_write();
      logic a0, a1, a2, a3, bsy;
      int   w0 = wr_cnt;
      i2c_start(); send_byte(8'hA0, a0); bsy = o_busy;
      send_byte(8'h03, a1); send_byte(8'h11, a2); send_byte(8'h22, a3); i2c_stop();
      $display("[TB] write S,A0,03,11,22,P acks=%b%b%b%b", a0, a1, a2, a3);
      tests++;
      if ({a0, a1, a2, a3} !== 4'b0000) begin fails++; $display("FAIL write_acks: got %b%b%b%b expected 0000", a0, a1, a2, a3); end
      tests++;
      if (bsy !== 1'b1) begin fails++; $display("FAIL write_busy: got %b expected 1", bsy); end
      tests++;
      if (wr_cnt - w0 !== 2) begin fails++; $display("FAIL write_count: got %0d expected 2", wr_cnt - w0); end
      tests++;
      if (wr_addr_log[w0] !== 3 || wr_data_log[w0] !== 'h11) begin fails++;
         $display("FAIL write_first: got addr %0d data %h expected addr 3 data 11", wr_addr_log[w0], wr_data_log[w0]); end
      tests++;
      if (wr_addr_log[w0+1] !== 4 || wr_data_log[w0+1] !== 'h22) begin fails++;
         $display("FAIL write_second: got addr %0d data %h expected addr 4 data 22", wr_addr_log[w0+1], wr_data_log[w0+1]); end
      tests++;
      if (o_reg_addr !== 4'd5 || o_busy !== 1'b0) begin fails++;
         $display("FAIL write_end: got addr %0d busy %b expected addr 5 busy 0", o_reg_addr, o_busy); end
   endtask

   task automatic test_read();
      logic       a, b, c, d;
      logic [7:0] d0, d1;
      int         r0;
      i2c_start(); send_byte(8'hA0, a); send_byte(8'h02, a); send_byte(8'h5A, a); send_byte(8'hC3, a); i2c_stop();
      r0 = rd_cnt;
      i2c_start(); send_byte(8'hA0, a); send_byte(8'h02, b); i2c_rstart(); send_byte(8'hA1, c);
      recv_byte(1'b0, d0);
      tests++;
      if (o_ack_mstr !== 1'b0) begin fails++; $display("FAIL read_mack: got %b expected 0", o_ack_mstr); end
      recv_byte(1'b1, d1);
      d = o_sda;
      $display("[TB] read S,A0,02,Sr,A1 -> %h %h", d0, d1);
      tests++;
      if ({a, b, c} !== 3'b000) begin fails++; $display("FAIL read_acks: got %b%b%b expected 000", a, b, c); end
      tests++;
      if (d0 !== 8'h5A || d1 !== 8'hC3) begin fails++; $display("FAIL read_data: got %h %h expected 5a c3", d0, d1); end
      tests++;
      if (o_ack_mstr !== 1'b1 || d !== 1'b1) begin fails++;
         $display("FAIL read_nack: got ack_mstr %b sda %b expected 1 1", o_ack_mstr, d); end
      i2c_stop();
      tests++;
      if (rd_cnt - r0 !== 2 || rd_addr_log[r0] !== 2 || rd_addr_log[r0+1] !== 3) begin fails++;
         $display("FAIL read_strobes: got count %0d addrs %0d %0d expected 2 at 2 3", rd_cnt - r0, rd_addr_log[r0], rd_addr_log[r0+1]); end
      tests++;
      if (o_reg_addr !== 4'd4 || o_busy !== 1'b0) begin fails++;
         $display("FAIL read_end: got addr %0d busy %b expected 4 0", o_reg_addr, o_busy); end
   endtask

   task automatic test_wrap();
      logic a;
      int   w0 = wr_cnt;
      i2c_start(); send_byte(8'hA0, a); send_byte(8'h0F, a); send_byte(8'hAA, a); send_byte(8'hBB, a); i2c_stop();
      $display("[TB] write S,A0,0F,AA,BB,P (wrap)");
      tests++;
      if (wr_cnt - w0 !== 2 || wr_addr_log[w0] !== 15 || wr_data_log[w0] !== 'hAA
          || wr_addr_log[w0+1] !== 0 || wr_data_log[w0+1] !== 'hBB) begin fails++;
         $display("FAIL wrap_writes: got %0d writes (%0d,%h) (%0d,%h) expected (15,aa) (0,bb)",
                  wr_cnt - w0, wr_addr_log[w0], wr_data_log[w0], wr_addr_log[w0+1], wr_data_log[w0+1]); end
      tests++;
      if (o_reg_addr !== 4'd1) begin fails++; $display("FAIL wrap_ptr: got %0d expected 1", o_reg_addr); end
   endtask

   task automatic test_addr_nack();
      logic a0, a1, bsy;
      int   s0 = sda_low_cnt, w0 = wr_cnt, r0 = rd_cnt;
      i2c_start(); send_byte(8'hA2, a0); send_byte(8'h33, a1); bsy = o_busy; i2c_stop();
      $display("[TB] S,A2,33,P (foreign address) acks=%b%b", a0, a1);
      tests++;
      if ({a0, a1} !== 2'b11) begin fails++; $display("FAIL nack_addr: got %b%b expected 11", a0, a1); end
      tests++;
      if (sda_low_cnt != s0 || wr_cnt != w0 || rd_cnt != r0) begin fails++;
         $display("FAIL nack_quiet: got sda_low %0d wr %0d rd %0d expected 0 0 0", sda_low_cnt - s0, wr_cnt - w0, rd_cnt - r0); end
      tests++;
      if (bsy !== 1'b1 || o_busy !== 1'b0) begin fails++;
         $display("FAIL nack_busy: got before-P %b after-P %b expected 1 0", bsy, o_busy); end
   endtask

   task automatic test_bad_ptr();
      logic a0, a1, a2;
      int   w0 = wr_cnt;
      i2c_start(); send_byte(8'hA0, a0); send_byte(8'h20, a1); send_byte(8'h44, a2); i2c_stop();
      $display("[TB] S,A0,20,44,P (pointer out of range) acks=%b%b%b", a0, a1, a2);
      tests++;
      if ({a0, a1, a2} !== 3'b011) begin fails++; $display("FAIL badptr_acks: got %b%b%b expected 011", a0, a1, a2); end
      tests++;
      if (o_reg_addr !== 4'd1 || wr_cnt != w0) begin fails++;
         $display("FAIL badptr_state: got addr %0d writes %0d expected 1 0", o_reg_addr, wr_cnt - w0); end
   endtask

   task automatic test_reset_mid_read();
      logic a;
      int   w0;
      i2c_start(); send_byte(8'hA0, a); send_byte(8'h02, a); i2c_rstart(); send_byte(8'hA1, a);
      scl = 1'b0; fl_scl = 1'b1; tick(); fl_scl = 1'b0;
      repeat (3) tick();
      m_sda = 1'b1; mdl = 1'b1; tick(); mdl = 1'b0;
      tests++;
      if (o_sda !== 1'b0) begin fails++; $display("FAIL midrd_drive: got sda %b expected 0 (MSB of 5a)", o_sda); end
      rst = 1'b1; tick();
      $display("[TB] reset during read data");
      tests++;
      if (o_sda !== 1'b1 || o_busy !== 1'b0 || o_reg_addr !== 4'd0) begin fails++;
         $display("FAIL midrd_reset: got sda %b busy %b addr %0d expected 1 0 0", o_sda, o_busy, o_reg_addr); end
      rst = 1'b0; scl = 1'b1; m_sda = 1'b1; repeat (4) tick();
      w0 = wr_cnt;
      i2c_start(); send_byte(8'hA0, a); send_byte(8'h07, a); send_byte(8'h99, a); i2c_stop();
      $display("[TB] write S,A0,07,99,P after reset");
      tests++;
      if (wr_cnt - w0 !== 1 || wr_addr_log[w0] !== 7 || wr_data_log[w0] !== 'h99 || o_reg_addr !== 4'd8) begin fails++;
         $display("FAIL midrd_recover: got %0d writes (%0d,%h) addr %0d expected (7,99) addr 8",
                  wr_cnt - w0, wr_addr_log[w0], wr_data_log[w0], o_reg_addr); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_wrap();
      test_addr_nack();
      test_bad_ptr();
      test_reset_mid_read();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
